a51_stream_engine: RTL and testbench

- Parametrised next-generation A5/1 keystream engine with the standard R1/R2/R3 (19/22/23-bit) majority-clocked registers.
- Loads key and frame in parallel at start, then streams the keystream out as OUT_W-bit words over a valid/ready handshake with backpressure.
- Optional auto-frame mode increments the frame number and regenerates the keystream back-to-back.
- Sits between the key/frame store and the XOR/display path, and replaces the single-shot 128-bit keystream capture.

---
 rtl/a51_stream_engine.sv | 269 ++++++++++++++++++++++++++
 tb/tb_a51_stream_engine.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a51_stream_engine.sv
// a51_stream_engine: A5/1 keystream generator with parallel key/frame load,
// majority-clocked mixing and an OUT_W-bit valid/ready output stream.
// Optional auto-frame mode bumps the frame number and regenerates back-to-back.
module a51_stream_engine #(
   parameter int KEY_BITS   = 64,
   parameter int FRAME_BITS = 22,
   parameter int MIX_CYCLES = 100,
   parameter int KS_BITS    = 228,
   parameter int OUT_W      = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  auto_frame,
   input  logic [KEY_BITS-1:0]   key,
   input  logic [FRAME_BITS-1:0] frame,
   output logic [OUT_W-1:0]      ks_data,
   output logic                  ks_valid,
   input  logic                  ks_ready,
   output logic                  busy,
   output logic                  done,
   output logic [FRAME_BITS-1:0] frame_cnt
);

   localparam int NUM_WORDS = KS_BITS / OUT_W;
   localparam int MAX_LOAD  = (KEY_BITS > FRAME_BITS) ? KEY_BITS : FRAME_BITS;
   localparam int MAX_CNT   = (MAX_LOAD > MIX_CYCLES) ? MAX_LOAD : MIX_CYCLES;
   localparam int CNT_W     = $clog2(MAX_CNT + 1);
   localparam int WC_W      = $clog2(NUM_WORDS + 1);
   localparam int GC_W      = $clog2(OUT_W);

   // Feedback tap masks for the three LFSRs.
   localparam logic [18:0] R1_TAPS = 19'h72000;   // bits 18,17,16,13
   localparam logic [21:0] R2_TAPS = 22'h300000;  // bits 21,20
   localparam logic [22:0] R3_TAPS = 23'h700080;  // bits 22,21,20,7

   generate
      if (KS_BITS % OUT_W != 0) begin : g_ks_multiple_check
         $error("KS_BITS must be a multiple of OUT_W");
      end
      if (OUT_W < 2) begin : g_out_w_check
         $error("OUT_W must be at least 2");
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE,
      LOAD_KEY,
      LOAD_FRAME,
      MIX,
      OUTPUT
   } state_t;

   state_t                state_q, state_d;
   logic [18:0]           r1_q, r1_d;
   logic [21:0]           r2_q, r2_d;
   logic [22:0]           r3_q, r3_d;
   logic [KEY_BITS-1:0]   key_q, key_d;        // key kept for auto-frame reloads
   logic [KEY_BITS-1:0]   key_sr_q, key_sr_d;  // working copy, shifted out LSB first
   logic [FRAME_BITS-1:0] fr_sr_q, fr_sr_d;
   logic [FRAME_BITS-1:0] frame_q, frame_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [OUT_W-2:0]      gather_q, gather_d;
   logic [GC_W-1:0]       gcnt_q, gcnt_d;
   logic [OUT_W-1:0]      out_q, out_d;
   logic                  valid_q, valid_d;
   logic                  done_q, done_d;
   logic [WC_W-1:0]       w_prod_q, w_prod_d;
   logic [WC_W-1:0]       w_acc_q, w_acc_d;

   logic                  maj, fb1, fb2, fb3, load_bit, out_bit;
   logic [18:0]           ld_r1, mj_r1;
   logic [21:0]           ld_r2, mj_r2;
   logic [22:0]           ld_r3, mj_r3;
   logic [OUT_W-1:0]      word_next;
   logic                  hs, last_hs, word_full, step_ok;

   assign ks_data   = out_q;
   assign ks_valid  = valid_q;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign frame_cnt = frame_q;

   // Candidate next register values for a load step and for a majority step.
   always_comb begin
      maj      = (r1_q[8] & r2_q[10]) | (r1_q[8] & r3_q[10]) | (r2_q[10] & r3_q[10]);
      fb1      = ^(r1_q & R1_TAPS);
      fb2      = ^(r2_q & R2_TAPS);
      fb3      = ^(r3_q & R3_TAPS);
      load_bit = (state_q == LOAD_KEY) ? key_sr_q[0] : fr_sr_q[0];
      ld_r1    = {r1_q[17:0], fb1 ^ load_bit};
      ld_r2    = {r2_q[20:0], fb2 ^ load_bit};
      ld_r3    = {r3_q[21:0], fb3 ^ load_bit};
      mj_r1    = (r1_q[8]  == maj) ? {r1_q[17:0], fb1} : r1_q;
      mj_r2    = (r2_q[10] == maj) ? {r2_q[20:0], fb2} : r2_q;
      mj_r3    = (r3_q[10] == maj) ? {r3_q[21:0], fb3} : r3_q;
      out_bit  = mj_r1[18] ^ mj_r2[21] ^ mj_r3[22];
      word_next = {gather_q, out_bit};
   end

   // Next-state and datapath update for the control FSM.
   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      state_d  = state_q;
      r1_d     = r1_q;
      r2_d     = r2_q;
      r3_d     = r3_q;
      key_d    = key_q;
      key_sr_d = key_sr_q;
      fr_sr_d  = fr_sr_q;
      frame_d  = frame_q;
      cnt_d    = cnt_q;
      gather_d = gather_q;
      gcnt_d   = gcnt_q;
      out_d    = out_q;
      valid_d  = valid_q;
      done_d   = 1'b0;
      w_prod_d = w_prod_q;
      w_acc_d  = w_acc_q;

      hs        = valid_q & ks_ready;
      last_hs   = hs && (w_acc_q == WC_W'(NUM_WORDS - 1));
      word_full = (gcnt_q == GC_W'(OUT_W - 1));
      // Stall only when this step would complete a word the output slot cannot take.
      step_ok   = (w_prod_q != WC_W'(NUM_WORDS)) && !(word_full && valid_q && !ks_ready);

      unique case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d  = LOAD_KEY;
               r1_d     = '0;
               r2_d     = '0;
               r3_d     = '0;
               key_d    = key;
               key_sr_d = key;
               frame_d  = frame;
               cnt_d    = '0;
            end
         end

         LOAD_KEY: begin
            r1_d     = ld_r1;
            r2_d     = ld_r2;
            r3_d     = ld_r3;
            key_sr_d = key_sr_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(KEY_BITS - 1)) begin
               state_d = LOAD_FRAME;
               cnt_d   = '0;
               fr_sr_d = frame_q;
            end
         end

         LOAD_FRAME: begin
            r1_d    = ld_r1;
            r2_d    = ld_r2;
            r3_d    = ld_r3;
            fr_sr_d = fr_sr_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
               state_d = MIX;
               cnt_d   = '0;
            end
         end

         MIX: begin
            r1_d  = mj_r1;
            r2_d  = mj_r2;
            r3_d  = mj_r3;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(MIX_CYCLES - 1)) begin
               state_d  = OUTPUT;
               cnt_d    = '0;
               gather_d = '0;
               gcnt_d   = '0;
               w_prod_d = '0;
               w_acc_d  = '0;
            end
         end

         OUTPUT: begin
            if (hs) begin
               valid_d = 1'b0;
               w_acc_d = w_acc_q + WC_W'(1);
            end
            if (step_ok) begin
               r1_d     = mj_r1;
               r2_d     = mj_r2;
               r3_d     = mj_r3;
               gather_d = word_next[OUT_W-2:0];
               if (word_full) begin
                  out_d    = word_next;
                  valid_d  = 1'b1;
                  gcnt_d   = '0;
                  w_prod_d = w_prod_q + WC_W'(1);
               end else begin
                  gcnt_d = gcnt_q + GC_W'(1);
               end
            end
            if (last_hs) begin
               done_d  = 1'b1;
               valid_d = 1'b0;
               if (auto_frame) begin
                  state_d  = LOAD_KEY;
                  frame_d  = frame_q + FRAME_BITS'(1);
                  r1_d     = '0;
                  r2_d     = '0;
                  r3_d     = '0;
                  key_sr_d = key_q;
                  cnt_d    = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end

         default: state_d = IDLE;
      endcase

      // Abort wins over everything, including a simultaneous last handshake.
      if (abort && state_q != IDLE) begin
         state_d = IDLE;
         valid_d = 1'b0;
         done_d  = 1'b0;
      end
   end

   // State and datapath registers, cleared by the asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         r1_q     <= '0;
         r2_q     <= '0;
         r3_q     <= '0;
         key_q    <= '0;
         key_sr_q <= '0;
         fr_sr_q  <= '0;
         frame_q  <= '0;
         cnt_q    <= '0;
         gather_q <= '0;
         gcnt_q   <= '0;
         out_q    <= '0;
         valid_q  <= 1'b0;
         done_q   <= 1'b0;
         w_prod_q <= '0;
         w_acc_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q  <= state_d;
         r1_q     <= r1_d;
         r2_q     <= r2_d;
         r3_q     <= r3_d;
         key_q    <= key_d;
         key_sr_q <= key_sr_d;
         fr_sr_q  <= fr_sr_d;
         frame_q  <= frame_d;
         cnt_q    <= cnt_d;
         gather_q <= gather_d;
         gcnt_q   <= gcnt_d;
         out_q    <= out_d;
         valid_q  <= valid_d;
         done_q   <= done_d;
         w_prod_q <= w_prod_d;
         w_acc_q  <= w_acc_d;
      end
   end

endmodule

// File: tb/tb_a51_stream_engine.sv
// tb_a51_stream_engine: directed bench for a51_stream_engine (4-bit and 8-bit
// word instances) with a bit-serial A5/1 reference model.
module tb_a51_stream_engine;

   localparam logic [63:0] KEY = 64'hEFCDAB8967452312;

   logic        clk = 1'b0;
   logic        reset, start, start8, abort, auto_frame, ks_ready;
   logic [63:0] key;
   logic [21:0] frame;
   logic [3:0]  ks_data;
   logic        ks_valid, busy, done;
   logic [21:0] frame_cnt;
   logic [7:0]  ks_data8;
   logic        ks_valid8, busy8, done8;
   logic [21:0] frame_cnt8;

   int n_checks = 0;
   int n_errors = 0;

   logic [3:0]  got[$];
   logic [7:0]  got8[$];
   int          first_valid;
   logic        done_seen, done_busy, done_valid;
   logic [21:0] done_fc;

   always #5 clk = ~clk;

   a51_stream_engine dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .auto_frame(auto_frame),
      .key(key), .frame(frame), .ks_data(ks_data), .ks_valid(ks_valid),
      .ks_ready(ks_ready), .busy(busy), .done(done), .frame_cnt(frame_cnt)
   );

   a51_stream_engine #(.OUT_W(8), .KS_BITS(224)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .abort(abort), .auto_frame(auto_frame),
      .key(key), .frame(frame), .ks_data(ks_data8), .ks_valid(ks_valid8),
      .ks_ready(ks_ready), .busy(busy8), .done(done8), .frame_cnt(frame_cnt8)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Bit-serial reference: returns keystream bit i at index i.
   function automatic logic [227:0] a51_model(input logic [63:0] k, input logic [21:0] f);
      logic [18:0]  a;
      logic [21:0]  b;
      logic [22:0]  c;
      logic [227:0] ks;
      logic         bi, m, ca, cb, cc;
      a = '0; b = '0; c = '0; ks = '0;
      for (int i = 0; i < 86; i++) begin
         bi = (i < 64) ? k[i] : f[i-64];
         a = {a[17:0], a[18] ^ a[17] ^ a[16] ^ a[13] ^ bi};
         b = {b[20:0], b[21] ^ b[20] ^ bi};
         c = {c[21:0], c[22] ^ c[21] ^ c[20] ^ c[7] ^ bi};
      end
      for (int i = 0; i < 328; i++) begin
         ca = a[8]; cb = b[10]; cc = c[10];
         m = (ca & cb) | (ca & cc) | (cb & cc);
         if (ca == m) a = {a[17:0], a[18] ^ a[17] ^ a[16] ^ a[13]};
         if (cb == m) b = {b[20:0], b[21] ^ b[20]};
         if (cc == m) c = {c[21:0], c[22] ^ c[21] ^ c[20] ^ c[7]};
         if (i >= 100) ks[i-100] = a[18] ^ b[21] ^ c[22];
      end
      return ks;
   endfunction

   function automatic logic [7:0] exp_word(input logic [227:0] ks, input int idx, input int w);
      logic [7:0] v;
      v = '0;
      for (int b = 0; b < w; b++) v[w-1-b] = ks[idx*w + b];
      return v;
   endfunction

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Collect 4-bit words until done. mode 0: ready high; mode 1: random ready
   // plus an 8-cycle hold low once five words have been taken.
   task automatic collect(input int mode, input int budget);
      logic       prev_stall, held;
      logic [3:0] prev_data;
      int         hold_left;
      got.delete();
      first_valid = -1;
      done_seen   = 1'b0;
      prev_stall  = 1'b0;
      prev_data   = '0;
      held        = 1'b0;
      hold_left   = 0;
      for (int c = 0; c < budget && !done_seen; c++) begin
         @(posedge clk); #1;
         if (prev_stall) begin
            check("stall_valid", ks_valid, 1);
            check("stall_data", ks_data, prev_data);
         end
         if (ks_valid && first_valid < 0) first_valid = c + 1;
         if (done) begin
            done_seen  = 1'b1;
            done_busy  = busy;
            done_valid = ks_valid;
            done_fc    = frame_cnt;
         end else begin
            if (mode == 1 && got.size() == 5 && !held) begin
               held      = 1'b1;
               hold_left = 8;
            end
            if (hold_left > 0) begin
               ks_ready = 1'b0;
               hold_left--;
            end else if (mode == 1) begin
               ks_ready = 1'($urandom_range(0, 1));
            end else begin
               ks_ready = 1'b1;
            end
            if (ks_valid && ks_ready) got.push_back(ks_data);
            prev_stall = ks_valid && !ks_ready;
            prev_data  = ks_data;
         end
      end
      check("done_within_budget", done_seen, 1);
      ks_ready = 1'b1;
   endtask

   task automatic compare_words(input string tag, input logic [227:0] ks);
      check({tag, "_count"}, got.size(), 57);
      for (int i = 0; i < got.size() && i < 57; i++)
         check(tag, got[i], exp_word(ks, i, 4));
   endtask

   initial begin
      logic [227:0] ks_ref, ks_ref_wrap, ks_ref_zero;
      logic [227:0] stream;
      logic [7:0]   bits114;
      logic [3:0]   head [8];
      logic         d8, done_any;
      int           fv8;

      head = '{4'h5, 4'h3, 4'h4, 4'hE, 4'hA, 4'hA, 4'h5, 4'h8};
      ks_ref      = a51_model(KEY, 22'h134);
      ks_ref_wrap = a51_model(KEY, 22'h3FFFFF);
      ks_ref_zero = a51_model(KEY, 22'h0);

      reset = 1'b1; start = 1'b0; start8 = 1'b0; abort = 1'b0; auto_frame = 1'b0;
      ks_ready = 1'b1; key = KEY; frame = 22'h134;
      repeat (2) @(posedge clk);
      #1;
      check("reset_data", ks_data, 0);
      check("reset_valid", ks_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_frame_cnt", frame_cnt, 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Known vector, ready always high.
      do_start();
      collect(0, 1000);
      check("first_valid_latency", first_valid, 190);
      for (int i = 0; i < 8 && i < got.size(); i++) check("head_word", got[i], head[i]);
      stream = '0;
      for (int i = 0; i < got.size() && i < 57; i++)
         for (int b = 0; b < 4; b++) stream[4*i + b] = got[i][3-b];
      for (int j = 0; j < 8; j++) bits114[7-j] = stream[114 + j];
      check("bits_114_121", bits114, 8'h24);
      compare_words("known_word", ks_ref);
      check("done_valid_low", done_valid, 0);
      check("done_busy_low", done_busy, 0);
      @(posedge clk); #1;
      check("done_one_cycle", done, 0);
      check("idle_after_done", busy, 0);

      // Backpressure.
      do_start();
      collect(1, 3000);
      compare_words("bp_word", ks_ref);

      // Auto-frame wrap from all-ones to zero.
      frame = 22'h3FFFFF; auto_frame = 1'b1;
      do_start();
      collect(0, 1000);
      compare_words("wrap_first_word", ks_ref_wrap);
      check("wrap_frame_cnt", done_fc, 0);
      check("wrap_busy", done_busy, 1);
      auto_frame = 1'b0;
      collect(0, 1000);
      compare_words("wrap_second_word", ks_ref_zero);
      check("wrap_end_busy", done_busy, 0);

      // Abort during MIX.
      frame = 22'h134;
      do_start();
      repeat (119) @(posedge clk);
      #1;
      check("pre_abort_busy", busy, 1);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_mix_busy", busy, 0);
      check("abort_mix_valid", ks_valid, 0);
      done_any = done;
      repeat (5) begin
         @(posedge clk); #1;
         done_any = done_any | done;
      end
      check("abort_mix_no_done", done_any, 0);

      // Abort during OUTPUT with a word pending.
      ks_ready = 1'b0;
      do_start();
      for (int c = 0; c < 400 && !ks_valid; c++) begin
         @(posedge clk); #1;
      end
      check("pending_valid", ks_valid, 1);
      repeat (3) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_out_valid", ks_valid, 0);
      check("abort_out_busy", busy, 0);
      check("abort_out_done", done, 0);
      ks_ready = 1'b1;

      // Start and abort together in IDLE.
      start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      check("start_abort_busy", busy, 0);
      @(posedge clk); #1;
      check("start_abort_busy_later", busy, 0);

      // Asynchronous reset in OUTPUT, then a clean restart.
      ks_ready = 1'b0;
      do_start();
      for (int c = 0; c < 400 && !ks_valid; c++) begin
         @(posedge clk); #1;
      end
      check("reset_pre_valid", ks_valid, 1);
      check("reset_pre_data", ks_data, 4'h5);
      #3 reset = 1'b1;
      #1;
      check("async_reset_valid", ks_valid, 0);
      check("async_reset_data", ks_data, 0);
      check("async_reset_busy", busy, 0);
      check("async_reset_frame_cnt", frame_cnt, 0);
      check("async_reset_done", done, 0);
      #1 reset = 1'b0;
      ks_ready = 1'b1;
      @(posedge clk); #1;
      do_start();
      collect(0, 1000);
      check("restart_latency", first_valid, 190);
      compare_words("restart_word", ks_ref);

      // Byte-wide instance.
      start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      fv8 = -1; d8 = 1'b0; got8.delete();
      for (int c = 0; c < 1000 && !d8; c++) begin
         @(posedge clk); #1;
         if (done8) d8 = 1'b1;
         else begin
            if (ks_valid8 && fv8 < 0) fv8 = c + 1;
            if (ks_valid8) got8.push_back(ks_data8);
         end
      end
      check("w8_done", d8, 1);
      check("w8_latency", fv8, 194);
      check("w8_count", got8.size(), 28);
      if (got8.size() >= 3) begin
         check("w8_byte0", got8[0], 8'h53);
         check("w8_byte1", got8[1], 8'h4E);
         check("w8_byte2", got8[2], 8'hAA);
      end
      for (int i = 0; i < got8.size() && i < 28; i++)
         check("w8_word", got8[i], exp_word(ks_ref, i, 8));
      check("w8_frame_cnt", frame_cnt8, 22'h134);
      @(posedge clk); #1;
      check("w8_idle", busy8, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
